// File: rtl/debounce_pkg.sv
// Shared defaults and width helper for the debounce bank.
package debounce_pkg;

   localparam int unsigned DEB_TICK_DIV_DEFAULT = 4096;
   localparam int unsigned DEB_STABLE_DEFAULT   = 128;

   function automatic int unsigned deb_cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, clean level
// and registered rise/fall pulses.
module debounce_chan #(
   parameter int unsigned STABLE_SAMPLES = 128,
   parameter int unsigned CNT_W          = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic             s1_q, s1_d;
   logic             s2_q, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dout_q, dout_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_comb begin
      s1_d   = din;
      s2_d   = s1_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (tick) begin
         // Any sample agreeing with the current level restarts qualification.
         if (s2_q == dout_q) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_W'(STABLE_SAMPLES - 1)) begin
            cnt_d  = '0;
            dout_d = s2_q;
            rise_d = s2_q;
            fall_d = ~s2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         cnt_q  <= '0;
         dout_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign dout = dout_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer sharing one sample-tick prescaler.
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int unsigned CHANNELS       = 8,
   parameter int unsigned TICK_DIV       = DEB_TICK_DIV_DEFAULT,
   parameter int unsigned STABLE_SAMPLES = DEB_STABLE_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_change
);

   localparam int unsigned CNT_W = deb_cnt_w(STABLE_SAMPLES);
   localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [DIV_W-1:0] div_q, div_d;
   logic             tick;

   // With TICK_DIV=1 the counter sits at 0, which is also the terminal value.
   assign tick = (div_q == DIV_W'(TICK_DIV - 1));

   always_comb begin
      div_d = div_q + DIV_W'(1);
      if (tick) begin
         div_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_chan #(
         .STABLE_SAMPLES(STABLE_SAMPLES),
         .CNT_W         (CNT_W)
      ) u_chan (
         .clk  (clk),
         .rst_n(rst_n),
         .tick (tick),
         .din  (din[i]),
         .dout (dout[i]),
         .rise (rise[i]),
         .fall (fall[i])
      );
   end

   assign any_change = |(rise | fall);

endmodule
